// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADDU = 3'd2,
    OP_SUBU = 3'd3,
    OP_ADDS = 3'd4,
    OP_SUBS = 3'd5,
    OP_MULU = 3'd6,
    OP_SLTU = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between decode, the sequential ALU and writeback.
interface alu_seq_if import alu_pkg::*; #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             c_out;
  logic             overflow;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             busy;

  modport master (
    output in_valid, op, x, y, c_in, out_ready,
    input  in_ready, out_valid, z, c_out, overflow, lt, eq, gt, busy
  );

  modport slave (
    input  in_valid, op, x, y, c_in, out_ready,
    output in_ready, out_valid, z, c_out, overflow, lt, eq, gt, busy
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: bit 0 is consumed on the start edge,
// the remaining WIDTH-1 bits one per cycle; done marks the last busy cycle.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_x_ext;

  assign w_x_ext = {{WIDTH{1'b0}}, x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_acc    <= y[0] ? w_x_ext : '0;
      r_mcand  <= w_x_ext << 1;
      r_mplier <= y >> 1;
      r_cnt    <= CW'(WIDTH - 1);
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
      end
    end
  end

  assign done    = r_run && (r_cnt == '0);
  assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/add/sub/compare ops, iterative multiply,
// results and flags held in output registers until writeback takes them.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_alu_load;
  logic               w_mul_load;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_add;
  logic               w_lt;
  logic               w_eq;
  logic               w_gt;
  logic [WIDTH-1:0]   w_z;
  logic               w_c;
  logic               w_ovf;

  logic [WIDTH-1:0]   r_z;
  logic               r_c_out;
  logic               r_ovf;
  logic               r_lt;
  logic               r_eq;
  logic               r_gt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_next = (bus.op == OP_MULU) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (w_mul_done) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_state_next = (bus.op == OP_MULU) ? S_MUL : S_DONE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_MUL:  w_busy     = 1'b1;
      S_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_mul_start = w_accept && (bus.op == OP_MULU);
  assign w_alu_load  = w_accept && (bus.op != OP_MULU);
  assign w_mul_load  = (r_state == S_MUL) && w_mul_done;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .x       (bus.x),
    .y       (bus.y),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_sum  = {1'b0, bus.x} + {1'b0, bus.y} + {{WIDTH{1'b0}}, bus.c_in};
  assign w_diff = {1'b0, bus.x} - {1'b0, bus.y};
  assign w_add  = bus.x + bus.y;
  assign w_lt   = bus.x < bus.y;
  assign w_eq   = bus.x == bus.y;
  assign w_gt   = bus.x > bus.y;

  // Signed overflow is judged purely from operand and result sign bits.
  always_comb begin
    w_z   = '0;
    w_c   = 1'b0;
    w_ovf = 1'b0;
    case (bus.op)
      OP_AND:  w_z = bus.x & bus.y;
      OP_OR:   w_z = bus.x | bus.y;
      OP_ADDU: begin
        w_z   = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_ovf = w_sum[WIDTH];
      end
      OP_SUBU: begin
        w_z   = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_ovf = w_diff[WIDTH];
      end
      OP_ADDS: begin
        w_z   = w_add;
        w_ovf = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (w_add[WIDTH-1] != bus.x[WIDTH-1]);
      end
      OP_SUBS: begin
        w_z   = w_diff[WIDTH-1:0];
        w_ovf = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (w_diff[WIDTH-1] != bus.x[WIDTH-1]);
      end
      OP_SLTU: w_z = {{(WIDTH-1){1'b0}}, w_lt};
      default: ;
    endcase
  end

  // Compare flags are taken at accept for every op, including a multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lt <= w_lt;
        r_eq <= w_eq;
        r_gt <= w_gt;
      end
      if (w_alu_load) begin
        r_z     <= w_z;
        r_c_out <= w_c;
        r_ovf   <= w_ovf;
      end else if (w_mul_load) begin
        r_z     <= w_product[WIDTH-1:0];
        r_c_out <= 1'b0;
        r_ovf   <= |w_product[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.z         = r_z;
  assign bus.c_out     = r_c_out;
  assign bus.overflow  = r_ovf;
  assign bus.lt        = r_lt;
  assign bus.eq        = r_eq;
  assign bus.gt        = r_gt;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: arithmetic model plus scoreboard, checked every
// cycle a result is valid, with literal pins for the key vectors and timing.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] z;
    logic        c;
    logic        v;
    logic        lt;
    logic        eq;
    logic        gt;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  op_t         vop [10] = '{OP_AND, OP_OR, OP_ADDU, OP_SUBU, OP_SUBU,
                            OP_ADDS, OP_SUBS, OP_SLTU, OP_SLTU, OP_ADDU};
  logic [15:0] vx  [10] = '{16'hA5A5, 16'h1200, 16'h7FFF, 16'h0005, 16'h0010,
                            16'hFFFE, 16'h7FFF, 16'h0007, 16'h0009, 16'h0000};
  logic [15:0] vy  [10] = '{16'h0FF0, 16'h0034, 16'h8000, 16'h0007, 16'h0010,
                            16'h0001, 16'hFFFF, 16'h0007, 16'h0002, 16'h0000};
  logic        vc  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  // Plain integer arithmetic; signed overflow is a range check.
  function automatic res_t model(input op_t o, input logic [15:0] a,
                                 input logic [15:0] b, input logic ci);
    res_t r;
    int sa;
    int sb;
    int s;
    longint unsigned p;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r.lt = (a < b);
    r.eq = (a == b);
    r.gt = (a > b);
    case (o)
      OP_AND:  r.z = a & b;
      OP_OR:   r.z = a | b;
      OP_ADDU: begin
        s = int'(a) + int'(b) + int'(ci);
        r.z = s[15:0];
        r.c = (s > 65535);
        r.v = r.c;
      end
      OP_SUBU: begin
        s = int'(a) - int'(b);
        r.z = s[15:0];
        r.c = (a < b);
        r.v = r.c;
      end
      OP_ADDS: begin
        s = sa + sb;
        r.z = s[15:0];
        r.v = (s > 32767) || (s < -32768);
      end
      OP_SUBS: begin
        s = sa - sb;
        r.z = s[15:0];
        r.v = (s > 32767) || (s < -32768);
      end
      OP_MULU: begin
        p = 64'(a) * 64'(b);
        r.z = p[15:0];
        r.v = (p > 64'd65535);
      end
      OP_SLTU: r.z = (a < b) ? 16'd1 : 16'd0;
      default: ;
    endcase
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.z, bus.c_out, bus.overflow, bus.lt, bus.eq, bus.gt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input op_t o, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.x        = a;
    bus.y        = b;
    bus.c_in     = ci;
    #1;
    while (bus.in_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      exp_q.push_back(model(o, a, b, ci));
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = op_t'(3'($urandom_range(0, 7)));
    bus.x        = 16'($urandom);
    bus.y        = 16'($urandom);
    bus.c_in     = 1'($urandom);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("result_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("result", 32'(dut_res()), 32'(exp_q[0]));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0) begin
      $display("retire z=%h c_out=%b overflow=%b lt=%b eq=%b gt=%b",
               bus.z, bus.c_out, bus.overflow, bus.lt, bus.eq, bus.gt);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    int w;
    int k;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_AND;
    bus.x         = '0;
    bus.y         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'(dut_res()), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);

    issue(OP_ADDU, 16'hFFFF, 16'h0001, 1'b0, w);
    chk("addu_valid", 32'(bus.out_valid), 32'd1);
    chk("addu_z", 32'(bus.z), 32'h0000);
    chk("addu_c_out", 32'(bus.c_out), 32'd1);
    chk("addu_overflow", 32'(bus.overflow), 32'd1);
    chk("addu_gt", 32'(bus.gt), 32'd1);
    @(negedge clk);
    chk("idle_after_take", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      issue(vop[i], vx[i], vy[i], vc[i], w);
      chk("no_bubble", 32'(w), 32'd0);
    end
    issue(OP_ADDS, 16'h7FFF, 16'h0001, 1'b0, w);
    chk("adds_z", 32'(bus.z), 32'h8000);
    chk("adds_overflow", 32'(bus.overflow), 32'd1);
    issue(OP_SUBS, 16'h8000, 16'h0001, 1'b0, w);
    chk("subs_z", 32'(bus.z), 32'h7FFF);
    chk("subs_overflow", 32'(bus.overflow), 32'd1);

    issue(OP_MULU, 16'h0100, 16'h0100, 1'b0, w);
    k = 0;
    while (bus.busy === 1'b1 && k < 40) begin
      chk("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("mul_out_valid_low", 32'(bus.out_valid), 32'd0);
      k++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 32'(k), 32'd16);
    chk("mul_valid_at_17", 32'(bus.out_valid), 32'd1);
    chk("mul_z", 32'(bus.z), 32'h0000);
    chk("mul_overflow", 32'(bus.overflow), 32'd1);
    issue(OP_MULU, 16'h00FF, 16'h0101, 1'b0, w);
    wait_result();
    issue(OP_MULU, 16'hFFFF, 16'hFFFF, 1'b0, w);
    wait_result();
    @(negedge clk);

    bus.out_ready = 1'b0;
    issue(OP_SLTU, 16'h0003, 16'h000F, 1'b0, w);
    repeat (5) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_z", 32'(bus.z), 32'h0001);
      chk("bp_lt", 32'(bus.lt), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    issue(OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, w);
    chk("b2b_no_wait", 32'(w), 32'd0);
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_z", 32'(bus.z), 32'h3030);

    issue(OP_MULU, 16'h1234, 16'h5678, 1'b0, w);
    repeat (7) @(negedge clk);
    chk("mid_mul_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_outputs", 32'(dut_res()), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_OR, 16'h00F0, 16'h0F00, 1'b0, w);
    chk("post_abort_z", 32'(bus.z), 32'h0FF0);
    issue(OP_MULU, 16'h0003, 16'h0005, 1'b0, w);
    wait_result();
    chk("post_abort_mul_z", 32'(bus.z), 32'h000F);

    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It accepts one operation per transaction over a valid/ready interface and registers the result together with carry, overflow and compare flags. Signed arithmetic is two's complement. It adds an iterative unsigned multiply. It sits between the decode stage and writeback, and stalls upstream while a multiply is in progress.

## Interface
- WIDTH, 16, operand/result width (≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; transfer when in_valid & in_ready
- op  in  3  operation code (see Operation)
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- c_in  in  1  carry in (ADDU only)
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result; transfer when out_valid & out_ready
- z  out  WIDTH  result
- c_out  out  1  carry/borrow out
- overflow  out  1  overflow indication
- lt, eq, gt  out  1 each  unsigned compare of accepted x vs y
- busy  out  1  high in MUL state

## Operation
- Op codes:
  - 0 AND: z = x&y.
  - 1 OR: z = x|y.
  - 2 ADDU: {c_out,z} = x+y+c_in; overflow = c_out.
  - 3 SUBU: z = x−y; c_out = borrow (x<y unsigned); overflow = c_out.
  - 4 ADDS: z = x+y; overflow = signs of x and y equal and sign of z differs.
  - 5 SUBS: z = x−y; overflow = signs of x and y differ and sign of z differs from x.
  - 6 MULU: z = low WIDTH bits of x*y; overflow = high WIDTH bits nonzero.
  - 7 SLTU: z = {0…,x<y}.
- c_out is 0 for ops other than 2 and 3. overflow is 0 for ops 0, 1 and 7.
- lt/eq/gt are captured for every op, exactly one high; they are registered with z.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - Accept op 6 → MUL.
    - Accept any other op → DONE, with result registered on the same edge.
  - MUL: shift-add with one multiplier bit per cycle, WIDTH cycles, then → DONE. in_ready=0, busy=1.
  - DONE: out_valid=1 and all outputs are held stable.
    - out_ready=0 → stay in DONE.
    - out_ready=1 and no accept → IDLE.
    - out_ready=1 and in_valid → accept the new op on the same edge (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational.

## Timing
- Reset (async assert, sync-to-clk deassert by integrator):
  - state=IDLE.
  - z=0; c_out, overflow, lt, eq, gt, out_valid, busy = 0.
  - in_ready=1.
- Non-MUL latency: accept at edge N → out_valid high after edge N (visible cycle N+1).
- MUL latency: accept at edge N → busy high from N+1 for WIDTH cycles → out_valid after edge N+WIDTH+1.
- Throughput: one non-MUL op per cycle when out_ready is held high.
- Inputs are sampled only at the accept edge. Changes to x/y/op afterwards do not affect an op in flight.
- Reset during MUL or DONE aborts the op. The result is discarded and the reset values apply immediately.
- Accept and result-take on the same edge: the old result retires and the new op is captured. There is no bubble.
- out_ready asserted while out_valid=0 is ignored.

## Structure
- Package alu_pkg:
  - op enum (OP_AND…OP_SLTU).
  - state enum (S_IDLE, S_MUL, S_DONE).
- Sub-module alu_mul_iter (WIDTH):
  - Ports: start, x, y, done, 2*WIDTH product.
  - Implemented with a bit counter of $clog2(WIDTH+1) bits.
- The top level holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- WIDTH=16, ADDU: x=16'hFFFF, y=16'h0001, c_in=0 → z=16'h0000, c_out=1, overflow=1, gt=1, one cycle later.
- ADDS: x=16'h7FFF, y=16'h0001 → z=16'h8000, overflow=1. SUBS: x=16'h8000, y=16'h0001 → z=16'h7FFF, overflow=1.
- MULU: x=16'h0100, y=16'h0100 → z=16'h0000, overflow=1, busy for 16 cycles, out_valid at accept+17. Check in_ready=0 throughout.
- Backpressure: SLTU x=3, y=15, out_ready=0 for 5 cycles → z=1, lt=1 held stable. Then out_ready=1 with a new AND in_valid → back-to-back accept with no idle cycle.
- Reset mid-MUL: assert rst_n=0 at cycle 8 of a multiply → all outputs 0 and in_ready=1 immediately. The next op completes normally.
